if_scratch_loader: RTL

- Fetches a contiguous run of input-feature (IF) words from an IF SRAM and writes them into the circular IF scratchpad of a PE.
- Sits directly upstream of the PE's IF scratchpad and its consumer.
- The consumer owns the read (start) pointer; this block owns the write (end) pointer.
- Issue is throttled on scratchpad occupancy, so in-flight data is never dropped.

---
 rtl/if_loader_pkg.sv | 13 +
 rtl/if_scratch_loader_distance.sv | 19 +
 rtl/if_scratch_loader.sv | 129 ++++++++++++
 3 files changed

// File: rtl/if_loader_pkg.sv
// Shared types for the IF scratchpad loader: FSM state encoding and stall counter width.
package if_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int STALL_CNT_WIDTH = 16;

endpackage

// File: rtl/if_scratch_loader_distance.sv
// Ring distance from start_val to end_val on a SCRATCH_DEPTH-entry circular buffer;
// the depth need not be a power of two, so the wrap is handled explicitly.
module IF_distance_calculator #(
  parameter int ADDR_LEN      = 4,
  parameter int SCRATCH_DEPTH = 12
) (
  input  logic [ADDR_LEN-1:0] start_val,
  input  logic [ADDR_LEN-1:0] end_val,
  output logic [ADDR_LEN-1:0] distance
);

  localparam logic [ADDR_LEN-1:0] DEPTH_VAL = ADDR_LEN'(SCRATCH_DEPTH);

  always_comb begin
    if (end_val >= start_val) distance = end_val - start_val;
    else                      distance = DEPTH_VAL - (start_val - end_val);
  end

endmodule

// File: rtl/if_scratch_loader.sv
// Streams a run of IF SRAM words into the PE's circular IF scratchpad, throttled on occupancy.
// Optional stall_cycles counter output when IF_LOADER_STALL_CNT_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing SRAM reads while the ring has room
// DRAIN | last read in flight, writing it
// DONE  | one-cycle completion pulse
module if_scratch_loader
  import if_loader_pkg::*;
#(
  parameter int ADDR_LEN        = 4,
  parameter int SCRATCH_DEPTH   = 12,
  parameter int SCRATCH_WIDTH   = 16,
  parameter int SRAM_ADDR_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [SRAM_ADDR_WIDTH-1:0] base_addr,
  input  logic [SRAM_ADDR_WIDTH-1:0] word_count,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_read_addr,
  input  logic [SCRATCH_WIDTH-1:0]   sram_read_data,
  input  logic [ADDR_LEN-1:0]        rd_ptr,
  output logic                       scratch_wr_en,
  output logic [ADDR_LEN-1:0]        scratch_wr_addr,
  output logic [SCRATCH_WIDTH-1:0]   scratch_wr_data,
  output logic [ADDR_LEN-1:0]        wr_ptr,
  output logic                       busy,
`ifdef IF_LOADER_STALL_CNT_EN
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles,
`endif
  output logic                       done
);

  localparam logic [ADDR_LEN-1:0] LAST_SLOT = ADDR_LEN'(SCRATCH_DEPTH - 1);
  localparam logic [ADDR_LEN:0]   FULL_LVL  = (ADDR_LEN + 1)'(SCRATCH_DEPTH - 1);

  state_t                     state;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q;
  logic [SRAM_ADDR_WIDTH-1:0] remaining;
  logic                       inflight;
  logic [ADDR_LEN-1:0]        occ;
  logic                       full;
  logic                       issue;

  IF_distance_calculator #(
    .ADDR_LEN      (ADDR_LEN),
    .SCRATCH_DEPTH (SCRATCH_DEPTH)
  ) u_distance (
    .start_val (rd_ptr),
    .end_val   (wr_ptr),
    .distance  (occ)
  );

  // The in-flight word already owns a slot, so it counts against capacity.
  assign full  = ({1'b0, occ} + {{ADDR_LEN{1'b0}}, inflight}) >= FULL_LVL;
  assign issue = (state == FETCH) && (remaining != '0) && !full;

  assign sram_read_addr  = addr_q;
  assign scratch_wr_en   = inflight;
  assign scratch_wr_addr = wr_ptr;
  assign scratch_wr_data = inflight ? sram_read_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      wr_ptr    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      inflight <= 1'b0;
      done     <= 1'b0;
      if (inflight) wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            if (word_count != '0) begin
              addr_q    <= base_addr;
              remaining <= word_count;
              busy      <= 1'b1;
              state     <= FETCH;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        FETCH: begin
          if (issue) begin
            addr_q    <= addr_q + 1'b1;
            remaining <= remaining - 1'b1;
            inflight  <= 1'b1;
            if (remaining == SRAM_ADDR_WIDTH'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IF_LOADER_STALL_CNT_EN
  logic [STALL_CNT_WIDTH-1:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
    end else if (state == FETCH && remaining != '0 && full && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall_cycles = stall_cnt;
`endif

endmodule
